// File: rtl/switch_key_conditioner.sv
// Synchronises and debounces SW[9:0] and KEY[1:0], producing clean levels and edge pulses.
// Define KEY_REPEAT_EN to add auto-repeat key_press pulses while a key stays held.
module switch_key_conditioner #(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [9:0] sw_db,
  output logic [1:0] key_db,
  output logic [1:0] key_press,
  output logic [1:0] key_release,
  output logic       sw_change
);

  localparam int NB = 12;
  localparam int CW = $clog2(DB_CYCLES + 1);

  if (DB_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("switch_key_conditioner: invalid DB_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
  end

  logic [9:0]    sw_s1, sw_s2;
  logic [1:0]    key_s1, key_s2;
  logic [NB-1:0] lvl, db_q, db_nxt;
  logic [CW-1:0] cnt_q   [NB];
  logic [CW-1:0] cnt_nxt [NB];
  logic [1:0]    rpt_fire;

  // Keys become active-high here so every bit debounces the same way.
  assign lvl = {~key_s2, sw_s2};

  always_comb begin
    db_nxt = db_q;
    for (int i = 0; i < NB; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (lvl[i] == db_q[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
        db_nxt[i]  = lvl[i];
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  logic [RW-1:0] rpt_q   [2];
  logic [RW-1:0] rpt_nxt [2];

  // Down-counter loaded on the press edge; firing is suppressed on the release edge.
  always_comb begin
    rpt_fire = '0;
    for (int k = 0; k < 2; k++) begin
      rpt_nxt[k] = rpt_q[k];
      if (!db_nxt[10+k]) begin
        rpt_nxt[k] = '0;
      end else if (!db_q[10+k]) begin
        rpt_nxt[k] = RW'(REPEAT_DELAY - 1);
      end else if (rpt_q[k] == '0) begin
        rpt_fire[k] = 1'b1;
        rpt_nxt[k]  = RW'(REPEAT_PERIOD - 1);
      end else begin
        rpt_nxt[k] = rpt_q[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q <= '{default: '0};
    end else begin
      rpt_q <= rpt_nxt;
    end
  end
`else
  assign rpt_fire = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1       <= '0;
      sw_s2       <= '0;
      key_s1      <= 2'b11;
      key_s2      <= 2'b11;
      db_q        <= '0;
      cnt_q       <= '{default: '0};
      key_press   <= '0;
      key_release <= '0;
      sw_change   <= 1'b0;
    end else begin
      sw_s1       <= SW;
      sw_s2       <= sw_s1;
      key_s1      <= KEY;
      key_s2      <= key_s1;
      db_q        <= db_nxt;
      cnt_q       <= cnt_nxt;
      key_press   <= (db_nxt[11:10] & ~db_q[11:10]) | rpt_fire;
      key_release <= ~db_nxt[11:10] & db_q[11:10];
      sw_change   <= |(db_nxt[9:0] ^ db_q[9:0]);
    end
  end

  assign sw_db  = db_q[9:0];
  assign key_db = db_q[11:10];

endmodule

// File: tb/tb_switch_key_conditioner.sv
// Directed bench for switch_key_conditioner with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_switch_key_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] SW;
  logic [1:0] KEY;
  logic [9:0] sw_db;
  logic [1:0] key_db, key_press, key_release;
  logic       sw_change;

  always #5 clk = ~clk;

  switch_key_conditioner #(
    .DB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .SW(SW), .KEY(KEY),
    .sw_db(sw_db), .key_db(key_db), .key_press(key_press),
    .key_release(key_release), .sw_change(sw_change)
  );

  typedef struct {
    logic       rst;
    logic [9:0] sw;
    logic [1:0] key;
    int         n;
    logic [9:0] e_swdb;
    logic [1:0] e_kdb;
    logic [1:0] e_press;
    logic [1:0] e_rel;
    logic       e_chg;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic [9:0] sw, input logic [1:0] key, input int n,
                     input logic [9:0] swdb, input logic [1:0] kdb, input logic [1:0] press,
                     input logic [1:0] rel, input logic chg);
    vec_t v;
    v.rst = r; v.sw = sw; v.key = key; v.n = n;
    v.e_swdb = swdb; v.e_kdb = kdb; v.e_press = press; v.e_rel = rel; v.e_chg = chg;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [16:0] act, input logic [16:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got {sw_db,key_db,press,rel,chg}=%h expected %h", name, idx, act, exp);
    end
  endtask

  logic [40:0] exp6;

  initial begin
    rst = 1'b1;
    SW  = '0;
    KEY = 2'b11;

    // reset, then idle
    add(1, 10'h000, 2'b11, 2,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b11, 20, 10'h000, 2'b00, 2'b00, 2'b00, 0);
    // KEY[0] press held 10 cycles, then release
    add(0, 10'h000, 2'b10, 5,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b10, 1,  10'h000, 2'b01, 2'b01, 2'b00, 0);
    add(0, 10'h000, 2'b10, 4,  10'h000, 2'b01, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b11, 5,  10'h000, 2'b01, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b11, 1,  10'h000, 2'b00, 2'b00, 2'b01, 0);
    add(0, 10'h000, 2'b11, 4,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    // SW[3] bounce: runs of 1 and 3 never reach the threshold
    add(0, 10'h008, 2'b11, 1,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b11, 1,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h008, 2'b11, 1,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b11, 1,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h008, 2'b11, 3,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b11, 8,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    // all switches up together, then all down
    add(0, 10'h3FF, 2'b11, 5,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h3FF, 2'b11, 1,  10'h3FF, 2'b00, 2'b00, 2'b00, 1);
    add(0, 10'h3FF, 2'b11, 3,  10'h3FF, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b11, 5,  10'h3FF, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b11, 1,  10'h000, 2'b00, 2'b00, 2'b00, 1);
    add(0, 10'h000, 2'b11, 2,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    // both keys pressed and released together
    add(0, 10'h000, 2'b00, 5,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b00, 1,  10'h000, 2'b11, 2'b11, 2'b00, 0);
    add(0, 10'h000, 2'b00, 1,  10'h000, 2'b11, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b11, 5,  10'h000, 2'b11, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b11, 1,  10'h000, 2'b00, 2'b00, 2'b11, 0);
    add(0, 10'h000, 2'b11, 1,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    // KEY[1] counter at 3, reset for one cycle, full latency restarts
    add(0, 10'h000, 2'b01, 5,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    add(1, 10'h000, 2'b01, 1,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b01, 5,  10'h000, 2'b00, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b01, 1,  10'h000, 2'b10, 2'b10, 2'b00, 0);
    add(0, 10'h000, 2'b01, 2,  10'h000, 2'b10, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b11, 5,  10'h000, 2'b10, 2'b00, 2'b00, 0);
    add(0, 10'h000, 2'b11, 1,  10'h000, 2'b00, 2'b00, 2'b10, 0);
    add(0, 10'h000, 2'b11, 2,  10'h000, 2'b00, 2'b00, 2'b00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        rst = tbl[i].rst;
        SW  = tbl[i].sw;
        KEY = tbl[i].key;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d", i), j, {sw_db, key_db, key_press, key_release, sw_change},
              {tbl[i].e_swdb, tbl[i].e_kdb, tbl[i].e_press, tbl[i].e_rel, tbl[i].e_chg});
      end
    end

    // KEY[0] held 30 cycles: press pulse edges, optional repeats, single release at edge 36
    exp6 = '0;
    exp6[6] = 1'b1;
`ifdef KEY_REPEAT_EN
    exp6[16] = 1'b1; exp6[19] = 1'b1; exp6[22] = 1'b1;
    exp6[25] = 1'b1; exp6[28] = 1'b1; exp6[31] = 1'b1; exp6[34] = 1'b1;
`endif
    rst = 1'b0;
    SW  = '0;
    for (int e = 1; e <= 40; e++) begin
      KEY = (e <= 30) ? 2'b10 : 2'b11;
      @(posedge clk);
      #1;
      check("hold_repeat", e, {7'd0, key_press, key_release, 8'd0},
            {7'd0, 1'b0, exp6[e], 1'b0, (e == 36), 8'd0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
